// File: rtl/sort_accel_ctrl.sv
// ---------------------------------------------------------------------------
// sort_accel_ctrl
//
// Memory-mapped control stage between a simple register-access port and a
// pipelined sorting network. Software loads N = 2**LOG_INPUT_NUM input words,
// writes START, and the block launches one sort with a single-cycle x_valid
// pulse. It then counts cycles until y_valid, captures the sorted vector into
// result registers, or aborts with a timeout and resets the sorter.
//
// Register map (byte offsets, bits [1:0] ignored):
//   0x00        CTRL   W: bit0 START, bit1 CLEAR   R: {29'b0, timeout, done, busy}
//   0x04        COUNT  RO, cycles from x_valid to y_valid of the last sort
//   0x40 + 4*i  IN[i]  RW, low DATA_WIDTH bits, read zero-extended
//   0x80 + 4*i  OUT[i] RO, sorted result
//
// Ports:
//   clk, resetn                 clock (posedge) and asynchronous active-low reset
//   req_valid/req_write/
//   req_addr/req_wdata          register access request
//   req_ready                   request accepted this cycle (= !resp_valid)
//   resp_valid/resp_rdata/
//   resp_err                    one-cycle registered response
//   sort_rst                    active-high reset to the sorting network
//   x_valid, x                  launch pulse and packed input vector
//   y_valid, y                  sorter result strobe and packed sorted vector
// ---------------------------------------------------------------------------
module sort_accel_ctrl #(
    parameter int LOG_INPUT_NUM = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 256
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      req_valid,
    input  logic                                      req_write,
    input  logic [7:0]                                req_addr,
    input  logic [31:0]                               req_wdata,
    output logic                                      req_ready,
    output logic                                      resp_valid,
    output logic [31:0]                               resp_rdata,
    output logic                                      resp_err,
    output logic                                      sort_rst,
    output logic                                      x_valid,
    output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  x,
    input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  y,
    input  logic                                      y_valid
);

    localparam int          N          = 2 ** LOG_INPUT_NUM;
    localparam logic [4:0]  N5         = 5'(N);
    localparam logic [15:0] TIMEOUT_16 = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic                    done_reg;
    logic                    timeout_reg;
    logic [15:0]             count_reg;
    logic [1:0]              srst_cnt_reg;
    logic [DATA_WIDTH-1:0]   in_reg  [N];
    logic [DATA_WIDTH-1:0]   out_reg [N];

    // Decode / control strobes
    logic [5:0]               widx;
    logic [LOG_INPUT_NUM-1:0] eidx;
    logic                     accept;
    logic                     busy;
    logic                     hit_ctrl, hit_count, hit_in, hit_out;
    logic                     err_next;
    logic [31:0]              rdata_next;
    logic                     clear_fire, start_fire, in_write;
    logic                     capture_fire, timeout_fire;
    logic [15:0]              count_inc;

    // Address bits [1:0] and write-data bits above DATA_WIDTH carry no meaning.
    logic unused_ok;
    assign unused_ok = ^{req_addr[1:0], req_wdata};

    always_comb begin
        widx       = req_addr[7:2];
        eidx       = req_addr[LOG_INPUT_NUM+1:2];
        accept     = req_valid && req_ready;
        busy       = (state_reg != S_IDLE);
        hit_ctrl   = (widx == 6'd0);
        hit_count  = (widx == 6'd1);
        hit_in     = (widx[5:4] == 2'b01) && ({1'b0, widx[3:0]} < N5);
        hit_out    = (widx[5:4] == 2'b10) && ({1'b0, widx[3:0]} < N5);

        err_next   = 1'b0;
        rdata_next = 32'd0;
        if (!(hit_ctrl || hit_count || hit_in || hit_out)) begin
            err_next = 1'b1;
        end else if (req_write) begin
            if (hit_count || hit_out) begin
                err_next = 1'b1;
            end else if (hit_in && busy) begin
                err_next = 1'b1;
            end else if (hit_ctrl && busy && (req_wdata[1:0] != 2'b00)) begin
                err_next = 1'b1;
            end
        end else begin
            if (hit_ctrl) begin
                rdata_next = {29'd0, timeout_reg, done_reg, busy};
            end else if (hit_count) begin
                rdata_next = 32'(count_reg);
            end else if (hit_in) begin
                rdata_next = 32'(in_reg[eidx]);
            end else begin
                rdata_next = 32'(out_reg[eidx]);
            end
        end

        // CLEAR has priority over START when both bits are written together.
        clear_fire   = accept && req_write && hit_ctrl && !busy && req_wdata[1];
        start_fire   = accept && req_write && hit_ctrl && !busy && req_wdata[0] && !req_wdata[1];
        in_write     = accept && req_write && hit_in && !busy;

        count_inc    = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
        capture_fire = (state_reg == S_WAIT) && y_valid;
        // A result arriving on the deadline cycle is still captured.
        timeout_fire = (state_reg == S_WAIT) && !y_valid && (count_inc == TIMEOUT_16);
    end

    // Response path: registered, one cycle after acceptance. req_ready is kept
    // as a register equal to !resp_valid so it is low while in reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            req_ready  <= !accept;
            resp_valid <= accept;
            resp_err   <= accept && err_next;
            resp_rdata <= (accept && !err_next) ? rdata_next : 32'd0;
        end
    end

    // Input and result registers, one slice per element.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    in_reg[gi] <= '0;
                end else if (in_write && (eidx == LOG_INPUT_NUM'(gi))) begin
                    in_reg[gi] <= req_wdata[DATA_WIDTH-1:0];
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    out_reg[gi] <= '0;
                end else if (clear_fire) begin
                    out_reg[gi] <= '0;
                end else if (capture_fire) begin
                    out_reg[gi] <= y[DATA_WIDTH*gi +: DATA_WIDTH];
                end
            end

            // x follows IN[] directly; IN[] is write-protected while busy so
            // x is stable from ISSUE through WAIT.
            assign x[DATA_WIDTH*gi +: DATA_WIDTH] = in_reg[gi];
        end
    endgenerate

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            x_valid      <= 1'b0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            count_reg    <= 16'd0;
            sort_rst     <= 1'b1;
            srst_cnt_reg <= 2'd2;
        end else begin
            x_valid <= 1'b0;

            // sort_rst stays high for exactly two cycles after a request (or
            // after reset release): load 2, drop the output as it reaches 0.
            if (clear_fire || timeout_fire) begin
                srst_cnt_reg <= 2'd2;
                sort_rst     <= 1'b1;
            end else if (srst_cnt_reg != 2'd0) begin
                srst_cnt_reg <= srst_cnt_reg - 2'd1;
                sort_rst     <= (srst_cnt_reg != 2'd1);
            end

            case (state_reg)
                S_IDLE: begin
                    if (clear_fire) begin
                        done_reg    <= 1'b0;
                        timeout_reg <= 1'b0;
                    end else if (start_fire) begin
                        state_reg   <= S_ISSUE;
                        x_valid     <= 1'b1;
                        done_reg    <= 1'b0;
                        timeout_reg <= 1'b0;
                        count_reg   <= 16'd0;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    count_reg <= count_inc;
                    if (capture_fire) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end else if (timeout_fire) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_accel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sort_accel_ctrl
//
// Self-checking bench for sort_accel_ctrl (N=4, 16-bit elements, TIMEOUT=16).
// A responder process plays the sorting network: it sorts whatever vector is
// presented on x_valid and returns it after a programmable latency. A
// register-level reference model (arrays plus flags) predicts every response.
// ---------------------------------------------------------------------------
module tb_sort_accel_ctrl;

    localparam int LOG_N = 2;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        sort_rst, x_valid, y_valid;
    logic [63:0] x, y;

    always #5 clk = ~clk;

    sort_accel_ctrl #(
        .LOG_INPUT_NUM (LOG_N),
        .DATA_WIDTH    (DW),
        .TIMEOUT       (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .sort_rst   (sort_rst),
        .x_valid    (x_valid),
        .x          (x),
        .y          (y),
        .y_valid    (y_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ sorter model
    function automatic logic [63:0] sort_vec(input logic [63:0] v);
        logic [DW-1:0] a [N];
        logic [DW-1:0] t;
        logic [63:0]   r;
        for (int i = 0; i < N; i++) a[i] = v[i*DW +: DW];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        r = '0;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i];
        return r;
    endfunction

    int          sorter_lat = -1;   // <0 never answers, 0 answers in the launch cycle
    int          cd         = 0;
    bit          stray_req  = 0;
    int          xv_cycles  = 0;
    logic [63:0] x_seen     = '0;
    int          sr_run     = 0;
    int          sr_pulses  = 0;
    int          last_run   = 0;

    initial begin
        y_valid = 1'b0;
        y       = '0;
        forever begin
            @(negedge clk);
            y_valid = 1'b0;
            if (sort_rst) sr_run++;
            else if (sr_run > 0) begin
                last_run = sr_run;
                sr_pulses++;
                sr_run = 0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    y_valid = 1'b1;
                    y       = sort_vec(x_seen);
                end
            end
            if (stray_req) begin
                y_valid   = 1'b1;
                y         = 64'hBEEF_1234_5A5A_0F0F;
                stray_req = 0;
            end
            if (x_valid) begin
                xv_cycles++;
                x_seen = x;
                if (sorter_lat == 0) begin
                    y_valid = 1'b1;
                    y       = sort_vec(x);
                end else if (sorter_lat > 0) begin
                    cd = sorter_lat;
                end
            end
        end
    end

    // -------------------------------------------------------- reference model
    logic [DW-1:0] in_m  [N];
    logic [DW-1:0] out_m [N];
    bit            done_m, tmo_m;
    int            count_m;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            in_m[i]  = '0;
            out_m[i] = '0;
        end
        done_m  = 0;
        tmo_m   = 0;
        count_m = 0;
    endtask

    function automatic logic [63:0] pack_model();
        logic [63:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = in_m[i];
        return r;
    endfunction

    task automatic model_apply(input bit w, input logic [7:0] a, input logic [31:0] d,
                               input bit busy, output bit e, output logic [31:0] rd,
                               output bit launch);
        int word;
        word   = int'(a[7:2]);
        e      = 0;
        rd     = 32'd0;
        launch = 0;
        if (word == 0) begin
            if (w) begin
                if (busy && d[1:0] != 2'b00) e = 1;
                else if (!busy && d[1]) begin
                    done_m = 0;
                    tmo_m  = 0;
                    for (int i = 0; i < N; i++) out_m[i] = '0;
                end else if (!busy && d[0]) begin
                    launch  = 1;
                    done_m  = 0;
                    tmo_m   = 0;
                    count_m = 0;
                end
            end else begin
                rd = {29'd0, tmo_m, done_m, busy};
            end
        end else if (word == 1) begin
            if (w) e = 1;
            else   rd = 32'(count_m);
        end else if (word >= 16 && word < 16 + N) begin
            if (w) begin
                if (busy) e = 1;
                else      in_m[word-16] = d[DW-1:0];
            end else begin
                rd = 32'(in_m[word-16]);
            end
        end else if (word >= 32 && word < 32 + N) begin
            if (w) e = 1;
            else   rd = 32'(out_m[word-32]);
        end else begin
            e = 1;
        end
    endtask

    // ------------------------------------------------------------ bus access
    task automatic access(input bit w, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e);
        int waitc = 0;
        @(negedge clk);
        while (!req_ready && waitc < 4) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) check("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 32'd0;
        @(negedge clk);
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("req_ready_during_resp", 64'(req_ready), 64'd0);
        rd = resp_rdata;
        e  = resp_err;
        $display("txn %s addr=%02h wdata=%08h rdata=%08h err=%0b",
                 w ? "WR" : "RD", a, d, rd, e);
    endtask

    task automatic access_chk(input string name, input bit w, input logic [7:0] a,
                              input logic [31:0] d, input bit busy, output bit launch);
        bit          e_exp;
        logic [31:0] rd_exp, rd_act;
        logic        e_act;
        model_apply(w, a, d, busy, e_exp, rd_exp, launch);
        access(w, a, d, rd_act, e_act);
        check({name, "_err"},   64'(e_act),  64'(e_exp));
        check({name, "_rdata"}, 64'(rd_act), 64'(rd_exp));
    endtask

    task automatic check_regs(input string tag);
        bit l;
        access_chk({tag, "_ctrl"},  0, 8'h00, 32'd0, 0, l);
        access_chk({tag, "_count"}, 0, 8'h04, 32'd0, 0, l);
        for (int i = 0; i < N; i++) begin
            access_chk({tag, "_out"}, 0, 8'(8'h80 + 4*i), 32'd0, 0, l);
            access_chk({tag, "_in"},  0, 8'(8'h40 + 4*i), 32'd0, 0, l);
        end
    endtask

    // One complete sort with the responder answering after 'lat' cycles.
    task automatic run_sort(input int lat);
        int          xv0, sr0;
        bit          l, finished, expect_done;
        logic [31:0] rd;
        logic        e;
        logic [63:0] s;
        for (int g = 0; g < 50 && cd != 0; g++) @(negedge clk);
        xv0        = xv_cycles;
        sr0        = sr_pulses;
        sorter_lat = lat;
        access_chk("start", 1, 8'h00, 32'h1, 0, l);
        if (lat <= 0 || lat >= 6) begin
            access_chk("busy_in_wr", 1, 8'h44, 32'h5, 1, l);
            access_chk("busy_start", 1, 8'h00, 32'h1, 1, l);
            access_chk("busy_clear", 1, 8'h00, 32'h2, 1, l);
        end
        finished = 0;
        rd       = 32'd0;
        for (int k = 0; k < 60 && !finished; k++) begin
            access(0, 8'h00, 32'd0, rd, e);
            if (rd[0] == 1'b0) finished = 1;
        end
        check("sort_finished", 64'(finished), 64'd1);
        expect_done = (lat >= 1 && lat <= TMO);
        if (expect_done) begin
            s = sort_vec(pack_model());
            for (int i = 0; i < N; i++) out_m[i] = s[i*DW +: DW];
            count_m = lat;
            done_m  = 1;
        end else begin
            count_m = TMO;
            tmo_m   = 1;
        end
        check("ctrl_after_sort", 64'(rd), 64'({29'd0, tmo_m, done_m, 1'b0}));
        check_regs("post_sort");
        check("x_valid_cycles", 64'(xv_cycles - xv0), 64'd1);
        check("x_at_launch", x_seen, pack_model());
        check("sort_rst_pulses", 64'(sr_pulses - sr0), expect_done ? 64'd0 : 64'd1);
        if (!expect_done) check("sort_rst_len", 64'(last_run), 64'd2);
    endtask

    task automatic clear_test(input logic [31:0] d);
        int xv0, sr0;
        bit l;
        xv0 = xv_cycles;
        sr0 = sr_pulses;
        access_chk("clear", 1, 8'h00, d, 0, l);
        repeat (4) @(negedge clk);
        check("clear_no_launch", 64'(xv_cycles - xv0), 64'd0);
        check("clear_rst_pulses", 64'(sr_pulses - sr0), 64'd1);
        check("clear_rst_len", 64'(last_run), 64'd2);
        check_regs("post_clear");
    endtask

    // -------------------------------------------------------------- vectors
    typedef struct {
        bit          w;
        logic [7:0]  addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          l;
        bit          e_m;
        logic [31:0] rd_m, rd_a;
        logic        e_a;
        int          xv0;
        logic [7:0]  a;
        logic [31:0] d;
        int          op, k, lat;

        tbl[0]  = '{0, 8'h00, 32'h0,          0, 32'h0,    "rd_ctrl"};
        tbl[1]  = '{0, 8'h04, 32'h0,          0, 32'h0,    "rd_count"};
        tbl[2]  = '{0, 8'h80, 32'h0,          0, 32'h0,    "rd_out0"};
        tbl[3]  = '{0, 8'h84, 32'h0,          0, 32'h0,    "rd_out1"};
        tbl[4]  = '{0, 8'h88, 32'h0,          0, 32'h0,    "rd_out2"};
        tbl[5]  = '{0, 8'h8C, 32'h0,          0, 32'h0,    "rd_out3"};
        tbl[6]  = '{0, 8'h20, 32'h0,          1, 32'h0,    "rd_unmapped20"};
        tbl[7]  = '{1, 8'h84, 32'h5,          1, 32'h0,    "wr_out1"};
        tbl[8]  = '{1, 8'h04, 32'h1,          1, 32'h0,    "wr_count"};
        tbl[9]  = '{1, 8'h40, 32'h12345678,   0, 32'h0,    "wr_in0"};
        tbl[10] = '{0, 8'h40, 32'h0,          0, 32'h5678, "rd_in0_trunc"};
        tbl[11] = '{1, 8'h47, 32'hABCD0042,   0, 32'h0,    "wr_in1_lowbits"};
        tbl[12] = '{0, 8'h44, 32'h0,          0, 32'h0042, "rd_in1"};
        tbl[13] = '{0, 8'h50, 32'h0,          1, 32'h0,    "rd_in4_unmapped"};
        tbl[14] = '{0, 8'h90, 32'h0,          1, 32'h0,    "rd_out4_unmapped"};
        tbl[15] = '{0, 8'hFC, 32'h0,          1, 32'h0,    "rd_top_unmapped"};
        tbl[16] = '{1, 8'h08, 32'h1,          1, 32'h0,    "wr_unmapped08"};
        tbl[17] = '{0, 8'h43, 32'h0,          0, 32'h5678, "rd_in0_lowbits"};
        tbl[18] = '{1, 8'h00, 32'h0,          0, 32'h0,    "wr_ctrl_nop"};
        tbl[19] = '{0, 8'h00, 32'h0,          0, 32'h0,    "rd_ctrl_again"};

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 32'd0;
        model_reset();

        // Reset state and release timing of sort_rst.
        repeat (3) @(negedge clk);
        check("rst_sort_rst",   64'(sort_rst),   64'd1);
        check("rst_x_valid",    64'(x_valid),    64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_resp_err",   64'(resp_err),   64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_x",          x,               64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("sort_rst_after_1_edge", 64'(sort_rst), 64'd1);
        @(negedge clk);
        check("sort_rst_after_2_edges", 64'(sort_rst), 64'd0);
        check("req_ready_after_rst", 64'(req_ready), 64'd1);

        // Table-driven register map vectors.
        for (int i = 0; i < NV; i++) begin
            model_apply(tbl[i].w, tbl[i].addr, tbl[i].wdata, 0, e_m, rd_m, l);
            access(tbl[i].w, tbl[i].addr, tbl[i].wdata, rd_a, e_a);
            check({tbl[i].name, "_err"},   64'(e_a),  64'(tbl[i].exp_err));
            check({tbl[i].name, "_rdata"}, 64'(rd_a), 64'(tbl[i].exp_rd));
        end

        // Back-to-back requests: accepted every other cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_resp_valid", 64'(resp_valid), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("b2b_req_ready",  64'(req_ready),  (i % 2 == 0) ? 64'd0 : 64'd1);
        end
        req_valid = 1'b0;

        // Directed sort: 7,3,9,1 with a 4-cycle sorter.
        access_chk("wr_in", 1, 8'h40, 32'd7, 0, l);
        access_chk("wr_in", 1, 8'h44, 32'd3, 0, l);
        access_chk("wr_in", 1, 8'h48, 32'd9, 0, l);
        access_chk("wr_in", 1, 8'h4C, 32'd1, 0, l);
        run_sort(4);
        check("directed_out0", 64'(out_m[0]), 64'd1);
        check("directed_out3", 64'(out_m[3]), 64'd9);

        // Timeout and boundary cases.
        run_sort(-1);
        run_sort(TMO);
        run_sort(TMO + 1);
        run_sort(0);
        access_chk("wr_in", 1, 8'h44, 32'hFFFF, 0, l);
        run_sort(9);

        // Stray y_valid while idle leaves OUT untouched.
        stray_req = 1;
        repeat (3) @(negedge clk);
        check_regs("stray");

        // CLEAR alone and CLEAR together with START.
        clear_test(32'h2);
        run_sort(5);
        clear_test(32'h3);

        // Randomised traffic against the model.
        for (int r = 0; r < 120; r++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                k = $urandom_range(0, N - 1);
                a = 8'(8'h40 + 4*k + $urandom_range(0, 3));
                d = $urandom;
                access_chk("rnd_in_wr", 1, a, d, 0, l);
            end else if (op <= 6) begin
                a = 8'($urandom_range(0, 255));
                access_chk("rnd_rd", 0, a, 32'd0, 0, l);
            end else if (op == 7) begin
                a = 8'($urandom_range(0, 255));
                if (a[7:2] == 6'd0) a = 8'h04;
                d = $urandom;
                access_chk("rnd_wr", 1, a, d, 0, l);
            end else if (op == 8) begin
                clear_test(32'(2 | $urandom_range(0, 1)));
            end else begin
                k = $urandom_range(0, 5);
                case (k)
                    0:       lat = -1;
                    1:       lat = 0;
                    2:       lat = TMO;
                    3:       lat = TMO + 1;
                    default: lat = $urandom_range(1, TMO);
                endcase
                run_sort(lat);
            end
        end

        // Reset asserted in the middle of WAIT; the later y_valid is ignored.
        for (int g = 0; g < 50 && cd != 0; g++) @(negedge clk);
        access_chk("wr_in", 1, 8'h40, 32'h1234, 0, l);
        xv0        = xv_cycles;
        sorter_lat = 10;
        access_chk("start_then_reset", 1, 8'h00, 32'h1, 0, l);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midwait_rst_x_valid",    64'(x_valid),    64'd0);
        check("midwait_rst_sort_rst",   64'(sort_rst),   64'd1);
        check("midwait_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("midwait_rst_x",          x,               64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        model_reset();
        check("midwait_x_valid_cycles", 64'(xv_cycles - xv0), 64'd1);
        check_regs("post_midwait_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_accel_ctrl.md
Name: sort_accel_ctrl

Overview:
Memory-mapped control stage between the AXI memory/peripheral model's simple register-access port and the pipelined sorting network (bitonic / odd-even merge / brick sort tops).
- Buffers the N = 2**LOG_INPUT_NUM input words and launches one sort with a single-cycle x_valid pulse.
- Waits for y_valid with a cycle counter and timeout.
- Captures the sorted vector into result registers and exposes status.

Parameters:
LOG_INPUT_NUM, 2, log2 of element count N
DATA_WIDTH, 32, element width; legal range 1..32
TIMEOUT, 256, max cycles from x_valid pulse to y_valid before abort; legal range 2..65535

Ports:
clk  in  1  clock, all logic on posedge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  register access request
req_write  in  1  1=write, 0=read
req_addr  in  8  byte offset, bits[1:0] ignored
req_wdata  in  32  write data
req_ready  out  1  request accepted this cycle
resp_valid  out  1  response strobe, one cycle
resp_rdata  out  32  read data, 0 on writes/errors
resp_err  out  1  access rejected or unmapped
sort_rst  out  1  active-high reset to sorting network
x_valid  out  1  launch pulse to sorter
x  out  DATA_WIDTH*N  packed inputs, element i at [DW*(i+1)-1:DW*i]
y  in  DATA_WIDTH*N  packed sorted outputs
y_valid  in  1  sorter output valid

Behaviour:
Reset (resetn low, async):
- All outputs 0 except sort_rst=1.
- Input regs, result regs, COUNT and status flags cleared; FSM to IDLE.
- sort_rst deasserts on the 2nd posedge after resetn rises.

Register map:
- 0x00 CTRL. Write bit0=START, bit1=CLEAR. Read {29'b0, timeout, done, busy}.
- 0x04 COUNT (RO). 16-bit cycles from x_valid to y_valid of last sort, zero-extended.
- 0x40+4*i IN[i] (RW). Stores low DATA_WIDTH bits; read zero-extended.
- 0x80+4*i OUT[i] (RO), i < N.
- Anything else unmapped: resp_err=1, no state change.

Handshake:
- req_ready = !resp_valid, so at most one access every two cycles.
- Response is registered: resp_valid rises the cycle after acceptance and is held exactly one cycle.

FSM states:
- IDLE: START → ISSUE; clears done/timeout, COUNT=0.
- ISSUE: one cycle, x_valid=1 → WAIT.
- WAIT: COUNT increments each cycle.
  - y_valid → capture y into OUT[], done=1 → IDLE.
  - COUNT reaching TIMEOUT without y_valid → timeout=1, sort_rst pulsed 2 cycles → IDLE.
- busy=1 in ISSUE and WAIT.

Boundaries:
- IN write, START or CLEAR while busy: resp_err=1, ignored.
- START and CLEAR in the same write: CLEAR wins. Clears done/timeout/OUT[], pulses sort_rst 2 cycles, no launch.
- y_valid in IDLE/ISSUE: ignored, OUT[] unchanged.
- y_valid on the same cycle COUNT hits TIMEOUT: capture wins, done=1, timeout=0.
- Writes to COUNT/OUT: resp_err=1.
- x is driven continuously from IN[] and is stable from the ISSUE cycle through WAIT.
- COUNT saturates at 16'hFFFF.
- resetn low mid-WAIT: immediate return to reset state; no capture.

Test Plan:
- Reset release → sort_rst high 2 cycles after resetn rises, then 0; CTRL reads 0; all OUT read 0.
- Write IN[0..3]=7,3,9,1, START; sorter model y_valid 4 cycles after x_valid with {9,7,3,1} packed ascending → x_valid exactly 1 cycle; CTRL reads done=1 busy=0; COUNT=4; OUT[0..3]=1,3,7,9.
- START with sorter never asserting y_valid, TIMEOUT=16 → timeout=1 at COUNT=16; sort_rst high 2 cycles; busy=0; OUT unchanged.
- Write IN[1]=5 while busy → resp_err=1; IN[1] readback keeps old value; sort result unaffected.
- Read 0x20 and write 0x84 → resp_err=1, resp_rdata=0; back-to-back requests → req_ready low on the cycle resp_valid is high.
- Assert resetn low during WAIT, then y_valid → no capture; CTRL=0, OUT=0, x_valid stays 0.
